// File: rtl/enqdeq_cmd_mux.sv
// Arbitrated command mux: pops the granted channel into a single-entry output register.
// Optional accept counter enabled by defining ENQDEQ_CMD_MUX_CNT_EN.
module enqdeq_cmd_mux #(
  parameter int N  = 16,
  parameter int W  = 64,
  parameter int CW = $clog2(N)
) (
  input  logic           user_clk,
  input  logic           reset_n,
  input  logic [N-1:0]   ch_valid,
  input  logic [N*W-1:0] ch_data,
  output logic [N-1:0]   ch_ready,
  output logic [N-1:0]   req,
  input  logic [N-1:0]   tkn,
  output logic           tkn_ack,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [CW-1:0]  out_ch,
  output logic           grant_err,
  output logic [31:0]    acc_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [W-1:0]    data_q, data_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic            err_q, err_d;
  logic            tkn_any, tkn_multi, slot_free;
  logic [W-1:0]    sel_data;
  logic [CW-1:0]   sel_ch;

  assign req = ch_valid;

  always_comb begin
    sel_data = '0;
    sel_ch   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (tkn[k]) begin
        sel_data = ch_data[k*W +: W];
        sel_ch   = CW'(k);
      end
    end
  end

  always_comb begin
    tkn_any   = |tkn;
    tkn_multi = |(tkn & (tkn - ONE));
    slot_free = (state_q == EMPTY) || out_ready;
    tkn_ack   = slot_free && tkn_any && !tkn_multi;
    ch_ready  = tkn_ack ? tkn : '0;

    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    err_d   = err_q | tkn_multi;
    if (tkn_ack) begin
      state_d = FULL;
      data_d  = sel_data;
      ch_d    = sel_ch;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign grant_err = err_q;

`ifdef ENQDEQ_CMD_MUX_CNT_EN
  logic [31:0] acc_cnt_q, acc_cnt_d;

  always_comb begin
    acc_cnt_d = acc_cnt_q + (tkn_ack ? 32'd1 : 32'd0);
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) acc_cnt_q <= '0;
    else          acc_cnt_q <= acc_cnt_d;
  end

  assign acc_cnt = acc_cnt_q;
`else
  assign acc_cnt = '0;
`endif

endmodule
